// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_unit_pkg;

  localparam int unsigned HZ_REGADDRSIZE = 5;
  localparam int unsigned HZ_XZR         = 31;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MEMWAIT = 2'd1,
    HZ_FAULT   = 2'd2
  } hz_state_e;

  // Stage-register controls, in the order consumed by the pipeline.
  typedef struct packed {
    logic pcwrite;
    logic ifidwrite;
    logic ifidflush;
    logic idexwrite;
    logic idexnop;
    logic exmemwrite;
    logic exmemnop;
    logic memwbnop;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_RUN = '{pcwrite: 1'b1, ifidwrite: 1'b1, ifidflush: 1'b0,
                                       idexwrite: 1'b1, idexnop: 1'b0, exmemwrite: 1'b1,
                                       exmemnop: 1'b0, memwbnop: 1'b0};

  localparam hz_ctrl_t HZ_CTRL_FREEZE = '{pcwrite: 1'b0, ifidwrite: 1'b0, ifidflush: 1'b0,
                                          idexwrite: 1'b0, idexnop: 1'b0, exmemwrite: 1'b0,
                                          exmemnop: 1'b0, memwbnop: 1'b1};

  localparam hz_ctrl_t HZ_CTRL_RESET = '{pcwrite: 1'b0, ifidwrite: 1'b0, ifidflush: 1'b0,
                                         idexwrite: 1'b0, idexnop: 1'b1, exmemwrite: 1'b0,
                                         exmemnop: 1'b1, memwbnop: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes and the data-memory
// wait FSM with timeout fault. Controls are same-cycle; state and counters are registered.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REGADDRSIZE = HZ_REGADDRSIZE,
  parameter int unsigned XZR         = HZ_XZR,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned COUNTSIZE   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REGADDRSIZE-1:0] idrs1,
  input  logic [REGADDRSIZE-1:0] idrs2,
  input  logic                   iduses1,
  input  logic                   iduses2,
  input  logic                   exmemread,
  input  logic                   exnop,
  input  logic [REGADDRSIZE-1:0] exrd,
  input  logic                   branchtaken,
  input  logic                   memreq,
  input  logic                   memready,
  output logic                   pcwrite,
  output logic                   ifidwrite,
  output logic                   ifidflush,
  output logic                   idexwrite,
  output logic                   idexnop,
  output logic                   exmemwrite,
  output logic                   exmemnop,
  output logic                   memwbnop,
  output logic                   fault,
  output logic [COUNTSIZE-1:0]   stallcnt,
  output logic [COUNTSIZE-1:0]   flushcnt
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  hz_state_e      state_q;
  hz_state_e      state_d;
  logic [WCW-1:0] waitcnt_q;
  logic [WCW-1:0] waitcnt_d;
  hz_ctrl_t       ctrl;
  logic           run_rules;
  logic           loaduse;
  logic           stall_inc;
  logic           flush_inc;

  // The zero register is never written, so it can never be a dependency.
  assign loaduse = exmemread && !exnop && (exrd != REGADDRSIZE'(XZR)) &&
                   ((iduses1 && (idrs1 == exrd)) || (iduses2 && (idrs2 == exrd)));

  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    ctrl      = HZ_CTRL_FREEZE;
    run_rules = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    case (state_q)
      HZ_RUN: begin
        if (memreq && !memready) begin
          state_d   = HZ_MEMWAIT;
          waitcnt_d = WCW'(1);
          stall_inc = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      HZ_MEMWAIT: begin
        if (memready) begin
          state_d   = HZ_RUN;
          waitcnt_d = '0;
          run_rules = 1'b1;
        end else if (waitcnt_q < WCW'(TIMEOUT)) begin
          waitcnt_d = waitcnt_q + WCW'(1);
          stall_inc = 1'b1;
        end else begin
          state_d = HZ_FAULT;
        end
      end
      HZ_FAULT: begin
        state_d = HZ_FAULT;
      end
      default: begin
        state_d   = HZ_RUN;
        waitcnt_d = '0;
      end
    endcase

    // A taken branch squashes the younger instruction, so its load-use stall is moot.
    if (run_rules) begin
      ctrl = HZ_CTRL_RUN;
      if (branchtaken) begin
        ctrl.ifidflush = 1'b1;
        ctrl.idexnop   = 1'b1;
        ctrl.exmemnop  = 1'b1;
        flush_inc      = 1'b1;
      end else if (loaduse) begin
        ctrl.pcwrite   = 1'b0;
        ctrl.ifidwrite = 1'b0;
        ctrl.idexnop   = 1'b1;
        stall_inc      = 1'b1;
      end
    end

    if (!rst_n) begin
      ctrl      = HZ_CTRL_RESET;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HZ_RUN;
      waitcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
    end
  end

  sat_counter #(.WIDTH(COUNTSIZE)) u_stallcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stallcnt)
  );

  sat_counter #(.WIDTH(COUNTSIZE)) u_flushcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flushcnt)
  );

  assign pcwrite    = ctrl.pcwrite;
  assign ifidwrite  = ctrl.ifidwrite;
  assign ifidflush  = ctrl.ifidflush;
  assign idexwrite  = ctrl.idexwrite;
  assign idexnop    = ctrl.idexnop;
  assign exmemwrite = ctrl.exmemwrite;
  assign exmemnop   = ctrl.exmemnop;
  assign memwbnop   = ctrl.memwbnop;
  assign fault      = (state_q == HZ_FAULT);

endmodule
